// File: rtl/lane_dispatch.sv
// lane_dispatch: 1-to-NUM_SEL registered demultiplexer with a one-entry holding register per lane.
// Optional macro LANE_DISPATCH_RR_EN: in_sel is ignored and words are dealt round-robin across lanes.
module lane_dispatch #(
  parameter int NUM_SEL   = 16,
  parameter int NUM_LOG   = 4,
  parameter int NUM_WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_WIDTH-1:0]         in_data,
  input  logic [NUM_LOG-1:0]           in_sel,
  output logic [NUM_SEL-1:0]           out_valid,
  input  logic [NUM_SEL-1:0]           out_ready,
  output logic [NUM_WIDTH*NUM_SEL-1:0] out_data,
  output logic                         sel_err,
  output logic                         busy
);

  logic [NUM_LOG-1:0] eff_sel;
  logic               sel_ok;
  logic [NUM_SEL-1:0] lane_hit;
  logic [NUM_SEL-1:0] fill;
  logic [NUM_SEL-1:0] full_vec;
  logic               accept;
  logic               sel_err_reg;
  logic               sel_err_next;

`ifdef LANE_DISPATCH_RR_EN
  localparam logic [NUM_LOG-1:0] LAST_LANE = NUM_LOG'(NUM_SEL - 1);

  logic [NUM_LOG-1:0] rr_ptr_reg;
  logic [NUM_LOG-1:0] rr_ptr_next;
  logic               unused_sel;

  assign unused_sel   = ^in_sel;
  assign eff_sel      = rr_ptr_reg;
  // The pointer wraps before reaching an invalid index, so the lane is always legal.
  assign sel_ok       = 1'b1;
  assign sel_err_next = 1'b0;

  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (accept) begin
      rr_ptr_next = (rr_ptr_reg == LAST_LANE) ? '0 : rr_ptr_reg + NUM_LOG'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg <= '0;
    end else begin
      rr_ptr_reg <= rr_ptr_next;
    end
  end
`else
  assign eff_sel = in_sel;

  if (NUM_SEL >= (1 << NUM_LOG)) begin : g_sel_all_valid
    assign sel_ok = 1'b1;
  end else begin : g_sel_range_check
    assign sel_ok = (32'(eff_sel) < NUM_SEL);
  end

  // Words aimed at a nonexistent lane are swallowed and flagged one cycle later.
  assign sel_err_next = accept & ~sel_ok;
`endif

  // Ready depends only on the addressed lane's occupancy and its consumer, never on in_valid.
  assign in_ready = ~sel_ok | (|(lane_hit & (~full_vec | out_ready)));
  assign accept   = in_valid & in_ready;

  for (genvar gi = 0; gi < NUM_SEL; gi++) begin : g_lane
    localparam logic [NUM_LOG-1:0] LANE_IDX = NUM_LOG'(gi);

    logic                 lane_full_reg;
    logic                 lane_full_next;
    logic [NUM_WIDTH-1:0] lane_data_reg;

    assign lane_hit[gi] = (eff_sel == LANE_IDX);
    assign fill[gi]     = accept & lane_hit[gi];

    // A fill wins over a same-cycle drain so a ready consumer sees one word per cycle.
    always_comb begin
      lane_full_next = lane_full_reg;
      if (fill[gi]) begin
        lane_full_next = 1'b1;
      end else if (out_ready[gi]) begin
        lane_full_next = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        lane_full_reg <= 1'b0;
        lane_data_reg <= '0;
      end else begin
        lane_full_reg <= lane_full_next;
        if (fill[gi]) begin
          lane_data_reg <= in_data;
        end
      end
    end

    assign full_vec[gi]                         = lane_full_reg;
    assign out_data[NUM_WIDTH*gi +: NUM_WIDTH]  = lane_data_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err_reg <= 1'b0;
    end else begin
      sel_err_reg <= sel_err_next;
    end
  end

  assign out_valid = full_vec;
  assign busy      = |full_vec;
  assign sel_err   = sel_err_reg;

endmodule

// File: tb/tb_lane_dispatch.sv
// Bench for lane_dispatch: table-driven per-cycle vectors plus a lane-tagged scoreboard on drained words.
// A second instance with NUM_SEL=12 covers the invalid-index path; LANE_DISPATCH_RR_EN selects the round-robin tests.
module tb_lane_dispatch;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [63:0]   in_data = '0;
  logic [3:0]    in_sel = '0;
  logic [15:0]   out_valid;
  logic [15:0]   out_ready = '0;
  logic [1023:0] out_data;
  logic          sel_err;
  logic          busy;

  logic          b_in_valid = 1'b0;
  logic          b_in_ready;
  logic [63:0]   b_in_data = '0;
  logic [3:0]    b_in_sel = '0;
  logic [11:0]   b_out_valid;
  logic [11:0]   b_out_ready = '0;
  logic [767:0]  b_out_data;
  logic          b_sel_err;
  logic          b_busy;

  always #5 clk = ~clk;

  lane_dispatch #(.NUM_SEL(16), .NUM_LOG(4), .NUM_WIDTH(64)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .sel_err(sel_err), .busy(busy)
  );

  lane_dispatch #(.NUM_SEL(12), .NUM_LOG(4), .NUM_WIDTH(64)) dut12 (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_sel(b_in_sel), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .sel_err(b_sel_err), .busy(b_busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Scoreboard: expected words tagged with their lane, popped when that lane drains.
  typedef struct {
    int          lane;
    logic [63:0] data;
  } sb_t;

  sb_t  sb_q[$];
  int   rr_model = 0;
  logic mon_en = 1'b0;

  always @(negedge clk) begin
    int hit;
    if (!rst_n) begin
      rr_model = 0;
    end else if (mon_en) begin
      for (int i = 0; i < 16; i++) begin
        if (out_valid[i] && out_ready[i]) begin
          hit = -1;
          for (int k = 0; k < sb_q.size(); k++) begin
            if (hit < 0 && sb_q[k].lane == i) hit = k;
          end
          if (hit < 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected lane=%0d actual=%h required=no_word", i, out_data[64*i +: 64]);
          end else begin
            $display("drain lane=%0d data=%h", i, out_data[64*i +: 64]);
            chk("sb_lane_data", out_data[64*i +: 64], sb_q[hit].data);
            sb_q.delete(hit);
          end
        end
      end
      if (in_valid && in_ready) begin
`ifdef LANE_DISPATCH_RR_EN
        sb_q.push_back('{rr_model, in_data});
        rr_model = (rr_model == 15) ? 0 : rr_model + 1;
`else
        sb_q.push_back('{int'(in_sel), in_data});
`endif
      end
    end
  end

  typedef struct {
    logic        vld;
    logic [3:0]  sel;
    logic [63:0] data;
    logic [15:0] rdy;
    logic        exp_rdy;
    logic [15:0] exp_ov;
    logic        exp_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic vld, input logic [3:0] sel, input logic [63:0] data,
                              input logic [15:0] rdy, input logic exp_rdy,
                              input logic [15:0] exp_ov, input logic exp_busy);
    vecs.push_back('{vld, sel, data, rdy, exp_rdy, exp_ov, exp_busy});
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    int   lane_now;
    logic exp_r;
    logic l2full;

    // Reset state
    #2 rst_n = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_sel_err", 64'(sel_err), 64'h0);
    chk("rst_slice3", out_data[192 +: 64], 64'h0);
    chk("rst_b_out_valid", 64'(b_out_valid), 64'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    mon_en = 1'b1;

`ifndef LANE_DISPATCH_RR_EN
    // Rows: inputs for this cycle; expectations are in_ready now and registered state before this edge.
    add(0, 4'd0, 64'h0,                   16'hFFFF, 1, 16'h0000, 0);
    add(1, 4'd3, 64'hA5A5_0000_0000_0003, 16'hFFFF, 1, 16'h0000, 0);
    add(0, 4'd3, 64'h0,                   16'hFFFF, 1, 16'h0008, 1);
    add(0, 4'd3, 64'h0,                   16'hFFFF, 1, 16'h0000, 0);
    add(1, 4'd5, 64'h11,                  16'hFFDF, 1, 16'h0000, 0);
    add(1, 4'd5, 64'h22,                  16'hFFDF, 0, 16'h0020, 1);
    add(1, 4'd5, 64'h22,                  16'hFFFF, 1, 16'h0020, 1);
    add(0, 4'd5, 64'h0,                   16'hFFDF, 0, 16'h0020, 1);
    add(0, 4'd5, 64'h0,                   16'hFFFF, 1, 16'h0020, 1);
    add(0, 4'd5, 64'h0,                   16'hFFFF, 1, 16'h0000, 0);
    add(1, 4'd1, 64'h100,                 16'hFFFF, 1, 16'h0000, 0);
    add(1, 4'd1, 64'h101,                 16'hFFFF, 1, 16'h0002, 1);
    add(0, 4'd1, 64'h0,                   16'hFFFF, 1, 16'h0002, 1);
    add(0, 4'd1, 64'h0,                   16'hFFFF, 1, 16'h0000, 0);
    for (int k = 0; k < 16; k++) begin
      add(1, 4'(k), 64'h1000 + 64'(k), 16'h0000, 1, 16'((32'd1 << k) - 32'd1), (k > 0));
    end
    add(0, 4'd4, 64'h0,                   16'h0000, 0, 16'hFFFF, 1);
    add(0, 4'd4, 64'h0,                   16'hFFFF, 1, 16'hFFFF, 1);
    add(0, 4'd0, 64'h0,                   16'hFFFF, 1, 16'h0000, 0);

    for (int r = 0; r < vecs.size(); r++) begin
      v = vecs[r];
      @(posedge clk); #1;
      in_valid = v.vld; in_sel = v.sel; in_data = v.data; out_ready = v.rdy;
      @(negedge clk);
      chk("vec_in_ready", 64'(in_ready), 64'(v.exp_rdy));
      chk("vec_out_valid", 64'(out_valid), 64'(v.exp_ov));
      chk("vec_busy", 64'(busy), 64'(v.exp_busy));
      chk("vec_sel_err", 64'(sel_err), 64'h0);
    end
    chk("sb_empty", 64'(sb_q.size()), 64'h0);

    // Invalid lane index on a 12-lane instance
    @(posedge clk); #1 b_in_valid = 1; b_in_sel = 4'd11; b_in_data = 64'hB;
    @(negedge clk);
    chk("b_ready_lane11", 64'(b_in_ready), 64'h1);
    chk("b_ov_initial", 64'(b_out_valid), 64'h0);
    @(posedge clk); #1 b_in_sel = 4'd12; b_in_data = 64'hC;
    @(negedge clk);
    chk("b_ready_sel12", 64'(b_in_ready), 64'h1);
    chk("b_ov_after_fill", 64'(b_out_valid), 64'h800);
    chk("b_err_before", 64'(b_sel_err), 64'h0);
    @(posedge clk); #1 b_in_sel = 4'd13; b_in_data = 64'hD;
    @(negedge clk);
    chk("b_ready_sel13", 64'(b_in_ready), 64'h1);
    chk("b_err_sel12", 64'(b_sel_err), 64'h1);
    chk("b_ov_unchanged12", 64'(b_out_valid), 64'h800);
    @(posedge clk); #1 b_in_valid = 0; b_in_sel = 4'd11;
    @(negedge clk);
    chk("b_err_sel13", 64'(b_sel_err), 64'h1);
    chk("b_ready_full11", 64'(b_in_ready), 64'h0);
    chk("b_ov_unchanged13", 64'(b_out_valid), 64'h800);
    chk("b_slice11", b_out_data[704 +: 64], 64'hB);
    @(posedge clk); #1 b_out_ready = 12'hFFF;
    @(negedge clk);
    chk("b_err_cleared", 64'(b_sel_err), 64'h0);
    chk("b_ready_draining", 64'(b_in_ready), 64'h1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b_ov_drained", 64'(b_out_valid), 64'h0);
    chk("b_busy_drained", 64'(b_busy), 64'h0);
`else
    // Round-robin: 20 accepts with in_sel held at 0 must walk lanes 0..15 then 0..3
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      in_valid = 1; in_sel = 4'd0; in_data = 64'h5000 + 64'(c); out_ready = 16'hFFFF;
      @(negedge clk);
      chk("rr_in_ready", 64'(in_ready), 64'h1);
      chk("rr_out_valid", 64'(out_valid), (c == 0) ? 64'h0 : (64'h1 << ((c - 1) % 16)));
      chk("rr_sel_err", 64'(sel_err), 64'h0);
    end
    @(posedge clk); #1 in_valid = 0;
    @(negedge clk);
    chk("rr_last_lane", 64'(out_valid), 64'h8);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rr_idle", 64'(out_valid), 64'h0);

    // Lane 2 blocked: the pointer must wait at lane 2 once it is full again
    l2full = 1'b0;
    for (int c = 0; c < 34; c++) begin
      @(posedge clk); #1;
      lane_now = rr_model;
      exp_r = !(lane_now == 2 && l2full);
      in_valid = 1; in_data = 64'h6000 + 64'(c); out_ready = 16'hFFFB;
      @(negedge clk);
      chk("rr_stall_ready", 64'(in_ready), 64'(exp_r));
      chk("rr_lane2_held", 64'(out_valid[2]), 64'(l2full));
      if (exp_r && lane_now == 2) l2full = 1'b1;
    end
    @(posedge clk); #1 in_valid = 0; out_ready = 16'hFFFF;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rr_drained", 64'(out_valid), 64'h0);
    chk("sb_empty", 64'(sb_q.size()), 64'h0);
`endif

    // Asynchronous reset with lanes 2 and 7 holding words
    @(posedge clk); #1 in_valid = 1; in_sel = 4'd2; in_data = 64'h2222; out_ready = 16'h0;
    @(posedge clk); #1 in_sel = 4'd7; in_data = 64'h7777;
    @(posedge clk); #1 in_valid = 0;
    @(negedge clk);
`ifndef LANE_DISPATCH_RR_EN
    chk("pre_rst_out_valid", 64'(out_valid), 64'h84);
`else
    chk("pre_rst_busy", 64'(busy), 64'h1);
`endif
    @(posedge clk); #2 rst_n = 0;
    sb_q.delete();
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'h0);
    chk("arst_slice2", out_data[128 +: 64], 64'h0);
    chk("arst_slice7", out_data[448 +: 64], 64'h0);
    chk("arst_busy", 64'(busy), 64'h0);
    @(posedge clk);
    @(posedge clk); #1 rst_n = 1; out_ready = 16'hFFFF;
    @(negedge clk);
    chk("post_rst_out_valid", 64'(out_valid), 64'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_rst_residual", 64'(out_valid), 64'h0);
    chk("post_rst_slice2", out_data[128 +: 64], 64'h0);
    chk("post_rst_sel_err", 64'(sel_err), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lane_dispatch.md
Name: lane_dispatch

Overview:
- Inverse of the NUM_SEL-to-1 output mux: a 1-to-NUM_SEL registered demultiplexer.
- Takes a single NUM_WIDTH-wide input stream, tagged with a lane index, and delivers each word to one of NUM_SEL parallel lanes.
- Each lane has its own valid/ready handshake and a one-entry holding register.
- Feeds parallel decompression engines from a single parser/token stream.

Parameters:
- NUM_SEL, 16, number of output lanes.
- NUM_LOG, 4, width of lane index; NUM_SEL <= 2**NUM_LOG.
- NUM_WIDTH, 64, data width per word/lane.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input word present.
- in_ready  output  1  input word accepted this cycle when in_valid&in_ready.
- in_data  input  NUM_WIDTH  input word.
- in_sel  input  NUM_LOG  destination lane index.
- out_valid  output  NUM_SEL  per-lane word valid.
- out_ready  input  NUM_SEL  per-lane consumer ready.
- out_data  output  NUM_WIDTH*NUM_SEL  lane i at bits [NUM_WIDTH*i+NUM_WIDTH-1 : NUM_WIDTH*i].
- sel_err  output  1  one-cycle pulse: word accepted with in_sel >= NUM_SEL and dropped.
- busy  output  1  OR of out_valid.

Behaviour:
- Reset (async assert, sync release): all out_valid=0, all out_data=0, sel_err=0, busy=0; round-robin pointer (if enabled)=0.
- Per lane i, holding register full_i drives out_valid[i]; out_data slice i is registered.
- in_ready is combinational. For s = effective lane:
  - s < NUM_SEL: in_ready = !full_s | out_ready[s].
  - s >= NUM_SEL: in_ready = 1.
  - in_ready must not depend on in_valid.
- Accept (in_valid&in_ready, s valid): next cycle full_s=1, out_data slice s=in_data. Latency 1 cycle, input to lane output.
- Lane drain: full_i & out_ready[i] with no fill to i -> full_i=0 next cycle. out_data slice i retains last value; don't-care, not cleared.
- Same-cycle drain and fill of lane s: new word loads, out_valid[s] stays 1. Full throughput of 1 word/cycle into one lane with a continuously ready consumer.
- While full_i & !out_ready[i]: out_data slice i and out_valid[i] held stable (no overwrite).
- Different lanes drain independently in the same cycle; only one lane is filled per cycle.
- Invalid index (s >= NUM_SEL, only possible if NUM_SEL < 2**NUM_LOG):
  - Word consumed and dropped; no lane changes.
  - sel_err=1 for exactly the next cycle.
- busy registered-equivalent: busy = |full, updated with full.
- Reset mid-operation: all held words discarded immediately; no partial output after release.

Optional Feature:
- Macro: LANE_DISPATCH_RR_EN.
- Defined: in_sel ignored. Effective lane s = internal pointer rr_ptr (NUM_LOG bits, reset 0).
  - rr_ptr advances by 1 on each accepted word; wraps from NUM_SEL-1 to 0. Never points at an invalid lane, so sel_err is tied 0.
  - Stalls (in_ready=0) while lane rr_ptr is full and not draining; no skipping.
- Undefined: in_sel selects the lane as above; no pointer logic exists.

Test Plan:
- Reset, then in_valid=1, in_sel=3, in_data=0xA5A5_0000_0000_0003, out_ready=all 1 -> next cycle out_valid=0x0008 and slice 3 equals data; following cycle out_valid=0.
- out_ready[5]=0; send two words to lane 5 (0x11, 0x22) -> first held at slice 5, out_valid[5]=1, in_ready=0 for the second. Raise out_ready[5] -> same cycle in_ready=1, second word accepted, next cycle slice 5=0x22, out_valid[5] still 1.
- Stream 16 back-to-back words to lanes 0..15 with out_ready=0 -> out_valid=0xFFFF after 16 cycles, busy=1. Release all ready -> out_valid=0 one cycle later, busy=0.
- NUM_SEL=12, NUM_LOG=4: send in_sel=13 -> in_ready=1, sel_err=1 for one cycle, out_valid unchanged.
- Lanes 2 and 7 full; assert rst_n=0 mid-cycle -> out_valid=0 and out_data=0 immediately (async). After release, no residual output.
- LANE_DISPATCH_RR_EN: 20 accepts with out_ready all 1, in_sel=0 -> lanes hit 0..15,0..3 in order. With out_ready[2]=0 and lane 2 full, a third pass stalls at lane 2 (in_ready=0).
